// File: rtl/inst_issue_queue_if.sv
// rtl/inst_issue_queue_if.sv - valid/ready push channel into the instruction issue queue
interface inst_issue_queue_if;
    logic        valid;
    logic [10:0] inst;
    logic        ready;

    modport master (output valid, output inst, input ready);
    modport slave  (input valid, input inst, output ready);
endinterface

// File: rtl/inst_issue_queue.sv
// rtl/inst_issue_queue.sv - instruction FIFO plus per-opcode issue pacer feeding the controller
module inst_issue_queue #(
    parameter int DEPTH   = 8,
    parameter int GAP_RD  = 2,
    parameter int GAP_WR  = 1,
    parameter int GAP_ALU = 5,
    parameter int CNT_W   = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     RUN,
    inst_issue_queue_if.slave        push,
    output logic [10:0]              Inst,
    output logic                     EN,
    output logic                     busy,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         issued_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, do_push, do_pop, can_issue;
    state_t        state, state_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic [10:0]   inst_n;
    logic          en_n, busy_n;

    function automatic logic [GW-1:0] gap_of(input logic [1:0] op);
        if (op[1])      return GW'(GAP_ALU);
        else if (op[0]) return GW'(GAP_WR);
        else            return GW'(GAP_RD);
    endfunction

    assign full       = (level == LW'(DEPTH));
    assign empty      = (level == '0);
    assign push.ready = !full;
    assign do_push    = push.valid && !full;
    assign can_issue  = RUN && !empty;

    // Storage needs no reset: clearing the pointers is what discards the contents.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push.inst;
    end

    always_comb begin
        state_n = state;
        gap_n   = gap_cnt;
        inst_n  = Inst;
        en_n    = 1'b0;
        busy_n  = busy;
        do_pop  = 1'b0;
        case (state)
            IDLE: begin
                if (can_issue) begin
                    do_pop  = 1'b1;
                    inst_n  = mem[rd_ptr];
                    en_n    = 1'b1;
                    busy_n  = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                gap_n   = gap_of(Inst[10:9]);
                state_n = GAP;
            end
            GAP: begin
                // A count of 1 marks the final EN-low cycle; issue may follow directly.
                if (gap_cnt <= GW'(1)) begin
                    gap_n = '0;
                    if (can_issue) begin
                        do_pop  = 1'b1;
                        inst_n  = mem[rd_ptr];
                        en_n    = 1'b1;
                        state_n = ISSUE;
                    end else begin
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end
                end else begin
                    gap_n = gap_cnt - GW'(1);
                end
            end
            default: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            Inst       <= '0;
            EN         <= 1'b0;
            busy       <= 1'b0;
            issued_cnt <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
        end else begin
            state   <= state_n;
            gap_cnt <= gap_n;
            Inst    <= inst_n;
            EN      <= en_n;
            busy    <= busy_n;
            if (do_pop) begin
                issued_cnt <= issued_cnt + CNT_W'(1);
                rd_ptr     <= rd_ptr + AW'(1);
            end
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_issue_queue.sv
// tb/tb_inst_issue_queue.sv - directed self-checking bench for inst_issue_queue
module tb_inst_issue_queue;
    logic        CLK = 1'b0;
    logic        RST;
    logic        RUN;
    logic [10:0] Inst;
    logic        EN, busy, empty;
    logic [3:0]  level;
    logic [7:0]  issued_cnt;
    int          n_assert = 0;
    int          n_fail   = 0;

    inst_issue_queue_if pif ();

    inst_issue_queue dut (
        .CLK        (CLK),
        .RST        (RST),
        .RUN        (RUN),
        .push       (pif),
        .Inst       (Inst),
        .EN         (EN),
        .busy       (busy),
        .empty      (empty),
        .level      (level),
        .issued_cnt (issued_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; RUN = 1'b0; pif.valid = 1'b0; pif.inst = '0;
        tick();
        RST = 1'b0;
    endtask

    task automatic push1(input logic [10:0] v);
        pif.valid = 1'b1; pif.inst = v;
        tick();
        pif.valid = 1'b0;
    endtask

    initial begin
        logic [11:0] pat;
        logic [10:0] exp_inst [4];
        logic [10:0] cur;
        int          k;
        int          pulses;

        // Reset state
        do_reset();
        chk("rst_en", 32'(EN), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ready", 32'(pif.ready), 1);
        chk("rst_level", 32'(level), 0);
        chk("rst_cnt", 32'(issued_cnt), 0);
        chk("rst_inst", 32'(Inst), 0);

        // Single WR: no bypass, one EN cycle, busy for 2 cycles
        RUN = 1'b1;
        push1(11'h2A5);
        chk("t1_no_bypass", 32'(EN), 0);
        chk("t1_level", 32'(level), 1);
        tick();
        chk("t1_en", 32'(EN), 1);
        chk("t1_inst", 32'(Inst), 32'h2A5);
        chk("t1_busy0", 32'(busy), 1);
        chk("t1_cnt", 32'(issued_cnt), 1);
        chk("t1_empty", 32'(empty), 1);
        tick();
        chk("t1_en_low", 32'(EN), 0);
        chk("t1_busy1", 32'(busy), 1);
        chk("t1_inst_hold", 32'(Inst), 32'h2A5);
        tick();
        chk("t1_busy_end", 32'(busy), 0);

        // Mixed opcodes back to back
        do_reset();
        push1(11'h0C0); push1(11'h24F); push1(11'h4D3); push1(11'h000);
        chk("t2_level4", 32'(level), 4);
        exp_inst[0] = 11'h0C0; exp_inst[1] = 11'h24F;
        exp_inst[2] = 11'h4D3; exp_inst[3] = 11'h000;
        pat = 12'b1001_0100_0001;
        k = 0; cur = '0;
        RUN = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t2_en_pat", 32'(EN), 32'(pat[11-i]));
            if (pat[11-i]) begin
                cur = exp_inst[k];
                k++;
            end
            chk("t2_inst", 32'(Inst), 32'(cur));
        end
        chk("t2_level0", 32'(level), 0);
        chk("t2_cnt", 32'(issued_cnt), 4);
        tick(3);
        chk("t2_idle", 32'(busy), 0);

        // Full FIFO: 9th push refused, push refused on pop edge while full
        do_reset();
        pif.valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            pif.inst = 11'(i);
            tick();
            if (i == 7) begin
                chk("t3_ready_full", 32'(pif.ready), 0);
                chk("t3_level8", 32'(level), 8);
            end
        end
        chk("t3_refused", 32'(level), 8);
        pif.inst = 11'h7FF;
        RUN = 1'b1;
        tick();
        RUN = 1'b0;
        chk("t3_pop_en", 32'(EN), 1);
        chk("t3_pop_inst", 32'(Inst), 0);
        chk("t3_pop_level", 32'(level), 7);
        chk("t3_pop_ready", 32'(pif.ready), 1);
        tick();
        pif.valid = 1'b0;
        chk("t3_refill_level", 32'(level), 8);
        chk("t3_refill_ready", 32'(pif.ready), 0);
        tick(2);
        chk("t3_idle", 32'(busy), 0);
        RUN = 1'b1;
        tick();
        chk("t3_next_inst", 32'(Inst), 1);
        chk("t3_next_en", 32'(EN), 1);
        RUN = 1'b0;

        // Reset in the middle of an ALU gap
        do_reset();
        push1(11'h4D3); push1(11'h2A5);
        RUN = 1'b1;
        tick();
        chk("t4_en", 32'(EN), 1);
        tick(2);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("t4_en", 32'(EN), 0);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_level", 32'(level), 0);
        chk("t4_cnt", 32'(issued_cnt), 0);
        chk("t4_inst", 32'(Inst), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_no_en", 32'(EN), 0);
        end

        // RUN dropped during a RD gap
        do_reset();
        push1(11'h0C0); push1(11'h011); push1(11'h2A5);
        RUN = 1'b1;
        tick();
        RUN = 1'b0;
        chk("t5_en", 32'(EN), 1);
        chk("t5_level", 32'(level), 2);
        tick(2);
        chk("t5_gap_busy", 32'(busy), 1);
        tick();
        chk("t5_busy_off", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_hold_en", 32'(EN), 0);
            chk("t5_hold_level", 32'(level), 2);
        end
        RUN = 1'b1;
        tick();
        chk("t5_resume_en", 32'(EN), 1);
        chk("t5_resume_inst", 32'(Inst), 32'h011);

        // issued_cnt wraps after 256 issues
        do_reset();
        pif.valid = 1'b1; pif.inst = 11'h2A5;
        RUN = 1'b1;
        pulses = 0;
        for (int i = 0; i < 2000 && pulses < 256; i++) begin
            tick();
            if (EN) begin
                pulses++;
                if (pulses == 255) chk("t6_cnt255", 32'(issued_cnt), 255);
                if (pulses == 256) chk("t6_wrap", 32'(issued_cnt), 0);
            end
        end
        chk("t6_pulses", 32'(pulses), 256);
        pif.valid = 1'b0;
        RUN = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_issue_queue.md
Name: inst_issue_queue

Overview:
- Instruction buffer and issue pacer directly upstream of the main controller.
- Accepts 11-bit instructions from a loader or testbench through a valid/ready push interface and stores them in a FIFO.
- Drives the controller's Inst/EN inputs with exactly one EN pulse per instruction.
- Holds EN low for the controller's fixed per-opcode busy time, so no instruction is ever presented while the controller is outside IDLE.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- GAP_RD, 2, EN-low cycles after issuing opcode 2'b00 (read).
- GAP_WR, 1, EN-low cycles after issuing opcode 2'b01 (write).
- GAP_ALU, 5, EN-low cycles after issuing opcode 2'b1x (add/sub).
- CNT_W, 8, width of issued-instruction counter.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  synchronous reset, active-high.
- RUN  in  1  issue enable; when low, no new instruction is issued.
- in_valid  in  1  push request.
- in_inst  in  11  instruction to push.
- in_ready  out  1  FIFO can accept; equals !full.
- Inst  out  11  instruction to controller; registered.
- EN  out  1  issue strobe to controller; registered; high one cycle per instruction.
- busy  out  1  high during the EN cycle and all following gap cycles.
- empty  out  1  FIFO holds no entries.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- issued_cnt  out  CNT_W  number of instructions issued; wraps.

Behaviour:
- Reset (RST high at posedge) values:
  - FIFO pointers and level = 0, empty = 1, in_ready = 1.
  - Inst = 0, EN = 0, busy = 0, issued_cnt = 0.
  - FSM in IDLE; gap counter = 0.
  - RST has priority over all other inputs.
- Push:
  - Occurs on a posedge with in_valid && in_ready; in_inst is written at the tail.
  - in_ready depends only on full. When full, the push is refused even if a pop happens in the same cycle.
  - A push into an empty FIFO is not issuable until the next cycle (no bypass).
- Pop:
  - Occurs only on an issue edge.
  - A push and a pop on the same edge (FIFO not full) leave level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE: if RUN && !empty at posedge → pop head into Inst, EN←1, busy←1, increment issued_cnt, next state ISSUE.
  - ISSUE (EN high this cycle): at posedge → EN←0; load gap counter from the Inst opcode:
    - Inst[10]=1 → GAP_ALU
    - Inst[10:9]=01 → GAP_WR
    - Inst[10:9]=00 → GAP_RD
  - ISSUE continued: if the loaded gap is 1, go to GAP with a final count; else go to GAP. The gap counter counts EN-low cycles, including the cycle right after ISSUE.
  - GAP: decrement the counter each cycle. At the last gap cycle's posedge:
    - if RUN && !empty → issue immediately (EN←1, state ISSUE);
    - else busy←0 and go to IDLE.
  - Required EN patterns for back-to-back issue:
    - WR: 1,0,1
    - RD: 1,0,0,1
    - ADD/SUB: 1,0,0,0,0,0,1
- Inst holds its last issued value while EN is low. Inst and EN never change except at an issue edge, the ISSUE→GAP edge, or reset.
- RUN deasserted mid-instruction: the current gap completes normally and no further pop occurs. Reasserting RUN resumes from IDLE.
- RST mid-gap: everything returns to reset values on that edge and FIFO contents are discarded, matching the controller's own reset to IDLE.
- issued_cnt wraps from 2^CNT_W−1 to 0.
- Opcode field is used only for gap selection. Instruction contents are passed through unmodified.

Test Plan:
- Reset, push WR 0x2A5 (01_010_100101), RUN=1 → EN high for exactly 1 cycle with Inst=0x2A5; busy high 2 cycles; issued_cnt=1; empty=1 afterwards.
- Push RD 0x0C0, WR 0x24F, ADD 0x4D3, then RD 0x000 while RUN=0; raise RUN → EN pattern 1,0,0,1,0,1,0,0,0,0,0,1; Inst values follow push order; level 4→0; issued_cnt=4.
- RUN=0, push 9 instructions with DEPTH=8 → in_ready=0 after the 8th push, the 9th is refused, level=8; one issue with in_valid held → in_ready=1 next cycle and level stays 8 after the push.
- During the ADD gap (2 cycles after EN), assert RST for 1 cycle → EN=0, busy=0, level=0, issued_cnt=0, Inst=0 on the next cycle; no EN for 3 cycles with RUN=1.
- Drop RUN during a RD gap with 2 entries queued → gap finishes, busy→0, no EN until RUN returns; then the next entry issues within 1 cycle.
- Preload issued_cnt path with 256 WR issues (CNT_W=8) → issued_cnt reads 0 after the 256th issue.
